axi_arbiter: RTL and testbench

AXI_ARBITER -- requirements
Module: axi_arbiter

---
 rtl/axi_arbiter_pkg.sv | 21 ++
 rtl/axi_arb_wdt.sv | 42 ++++
 rtl/axi_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axi_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_arbiter_pkg
//  Description : Shared definitions for the fetch/load-store bus arbiter:
//                the 2-bit FSM state encoding and the default abort timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SRV_IF  = 2'd1,
        SRV_MEM = 2'd2
    } arb_state_t;

    // Bus cycles without acknowledge before a transaction is aborted
    localparam logic [15:0] c_TIMEOUT_DEFAULT = 16'd255;

endpackage : axi_arbiter_pkg
`default_nettype wire

// File: rtl/axi_arb_wdt.sv
`default_nettype none
// ============================================================================
//  Module      : axi_arb_wdt
//  Description : Saturating 16-bit watchdog for one bus transaction.
//                Ports:
//                  clk, rst  - clock, asynchronous active-high reset
//                  i_clr     - restart count (transaction granted)
//                  i_en      - a serving cycle is in progress
//                  i_ack     - bus acknowledge in this cycle
//                  o_hit     - last permitted cycle elapsed without ack
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_arb_wdt
    import axi_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_ack,
    output logic o_hit
);

    logic [15:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 16'd0;
        end else if (i_clr) begin
            r_count <= 16'd0;
        end else if (i_en && !i_ack && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    // An ack in the final cycle wins over the abort.
    assign o_hit = i_en & ~i_ack & (r_count == (TIMEOUT - 16'd1));

endmodule : axi_arb_wdt
`default_nettype wire

// File: rtl/axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_arbiter
//  Description : Arbitrates a fetch port and a load/store port onto a single
//                shared memory bus, one transaction at a time, with an
//                alternating priority on contention and a watchdog abort.
//                Ports:
//                  clk, rst              - clock, asynchronous active-high reset
//                  if_*                  - fetch read port (req/addr in,
//                                          gnt/rvalid/rdata out)
//                  mem_*                 - load/store port (req/we/addr/wdata/
//                                          wmask in, gnt/rvalid/rdata out)
//                  bus_*                 - shared bus request out, ack/rdata in
//                  busy_o, busy_end_o    - pipeline-controller status
//                  err_o                 - timeout-abort pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [63:0] if_rdata_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [63:0] mem_addr_i,
    input  logic [63:0] mem_wdata_i,
    input  logic [7:0]  mem_wmask_i,
    output logic        mem_gnt_o,
    output logic        mem_rvalid_o,
    output logic [63:0] mem_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [63:0] bus_addr_o,
    output logic [63:0] bus_wdata_o,
    output logic [7:0]  bus_wmask_o,
    input  logic        bus_ack_i,
    input  logic [63:0] bus_rdata_i,
    output logic        busy_o,
    output logic        busy_end_o,
    output logic        err_o
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_last_mem;
    logic        r_we;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic        r_if_rvalid;
    logic        r_mem_rvalid;
    logic [63:0] r_if_rdata;
    logic [63:0] r_mem_rdata;
    logic        r_err;

    logic        w_if_gnt;
    logic        w_mem_gnt;
    logic        w_serving;
    logic        w_hit;
    logic        w_done;

    assign w_serving = (r_state != IDLE);
    assign w_done    = w_serving & (bus_ack_i | w_hit);

    axi_arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_if_gnt | w_mem_gnt),
        .i_en  (w_serving),
        .i_ack (bus_ack_i),
        .o_hit (w_hit)
    );

    // Next-state and grant decode. Grants are held off while reset is
    // asserted so that nothing is accepted before the first clean edge.
    always_comb begin
        w_state_nxt = r_state;
        w_if_gnt    = 1'b0;
        w_mem_gnt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    // MEM wins a tie unless it also won the previous grant.
                    if (mem_req_i && (!if_req_i || !r_last_mem)) begin
                        w_mem_gnt   = 1'b1;
                        w_state_nxt = SRV_MEM;
                    end else if (if_req_i) begin
                        w_if_gnt    = 1'b1;
                        w_state_nxt = SRV_IF;
                    end
                end
            end
            SRV_IF, SRV_MEM: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_mem   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 64'd0;
            r_wdata      <= 64'd0;
            r_wmask      <= 8'd0;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_if_rdata   <= 64'd0;
            r_mem_rdata  <= 64'd0;
            r_err        <= 1'b0;
        end else begin
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_err        <= 1'b0;
            if (w_if_gnt || w_mem_gnt) begin
                // Fetches are always reads: no write enable, no strobes.
                r_last_mem <= w_mem_gnt;
                r_addr     <= w_mem_gnt ? mem_addr_i : if_addr_i;
                r_we       <= w_mem_gnt & mem_we_i;
                r_wdata    <= w_mem_gnt ? mem_wdata_i : 64'd0;
                r_wmask    <= w_mem_gnt ? mem_wmask_i : 8'd0;
            end
            if (w_done) begin
                // An aborted transfer returns zero data alongside err_o.
                r_err <= ~bus_ack_i;
                if (r_state == SRV_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= bus_ack_i ? bus_rdata_i : 64'd0;
                end else begin
                    r_mem_rvalid <= 1'b1;
                    r_mem_rdata  <= bus_ack_i ? bus_rdata_i : 64'd0;
                end
            end
        end
    end

    assign if_gnt_o     = w_if_gnt;
    assign mem_gnt_o    = w_mem_gnt;
    assign if_rvalid_o  = r_if_rvalid;
    assign if_rdata_o   = r_if_rdata;
    assign mem_rvalid_o = r_mem_rvalid;
    assign mem_rdata_o  = r_mem_rdata;
    assign bus_req_o    = w_serving;
    assign bus_we_o     = r_we;
    assign bus_addr_o   = r_addr;
    assign bus_wdata_o  = r_wdata;
    assign bus_wmask_o  = r_wmask;
    assign busy_o       = w_serving;
    assign busy_end_o   = w_done;
    assign err_o        = r_err;

endmodule : axi_arbiter
`default_nettype wire

// File: tb/tb_axi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_arbiter
//  Description : Self-checking bench for axi_arbiter (TIMEOUT = 4): directed
//                scenarios with literal expectations followed by randomized
//                traffic compared cycle by cycle against a transaction-level
//                model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_arbiter;

    localparam int c_TO = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        bus_ack;
    logic [63:0] bus_rdata;

    logic        if_gnt_o, if_rvalid_o, mem_gnt_o, mem_rvalid_o;
    logic [63:0] if_rdata_o, mem_rdata_o;
    logic        bus_req_o, bus_we_o, busy_o, busy_end_o, err_o;
    logic [63:0] bus_addr_o, bus_wdata_o;
    logic [7:0]  bus_wmask_o;

    int n_total = 0;
    int n_pass  = 0;

    axi_arbiter #(
        .TIMEOUT (16'(c_TO))
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .mem_req_i    (mem_req),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_wmask_i  (mem_wmask),
        .mem_gnt_o    (mem_gnt_o),
        .mem_rvalid_o (mem_rvalid_o),
        .mem_rdata_o  (mem_rdata_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_wmask_o  (bus_wmask_o),
        .bus_ack_i    (bus_ack),
        .bus_rdata_i  (bus_rdata),
        .busy_o       (busy_o),
        .busy_end_o   (busy_end_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: who is being served (0 none, 1 IF, 2 MEM),
    // how long it has waited, what was captured at grant, and what the
    // response registers currently show.
    // ------------------------------------------------------------------
    int          m_who = 0;
    int          m_age = 0;
    logic        m_last_mem = 0;
    logic        m_we = 0;
    logic [63:0] m_addr = 0;
    logic [63:0] m_wdata = 0;
    logic        m_wd_ok = 1;
    logic [7:0]  m_wmask = 0;
    logic        m_if_rv = 0, m_mem_rv = 0, m_err = 0;
    logic [63:0] m_if_rd = 0, m_mem_rd = 0;
    logic        e_if_gnt = 0, e_mem_gnt = 0;

    always @(negedge clk) begin
        logic serving, hit, done;
        if (rst) begin
            e_if_gnt  = 1'b0;
            e_mem_gnt = 1'b0;
            chk("m_rst_ctl", {bus_req_o, busy_o, busy_end_o, if_gnt_o, mem_gnt_o,
                              if_rvalid_o, mem_rvalid_o, err_o, bus_we_o, bus_wmask_o}, 0);
            chk("m_rst_data", {bus_addr_o, bus_wdata_o}, 0);
            chk("m_rst_rdata", {if_rdata_o, mem_rdata_o}, 0);
            m_who = 0; m_age = 0; m_last_mem = 0; m_we = 0; m_addr = 0;
            m_wdata = 0; m_wd_ok = 1; m_wmask = 0;
            m_if_rv = 0; m_mem_rv = 0; m_err = 0; m_if_rd = 0; m_mem_rd = 0;
        end else begin
            serving   = (m_who != 0);
            e_mem_gnt = !serving && mem_req && (!if_req || !m_last_mem);
            e_if_gnt  = !serving && if_req && !e_mem_gnt;
            hit       = serving && (m_age == c_TO - 1) && !bus_ack;
            done      = serving && (bus_ack || hit);

            chk("m_gnt", {if_gnt_o, mem_gnt_o}, {e_if_gnt, e_mem_gnt});
            chk("m_bus", {bus_req_o, bus_we_o, bus_addr_o, bus_wmask_o},
                         {serving, m_we, m_addr, m_wmask});
            if (m_wd_ok) chk("m_bus_wdata", bus_wdata_o, m_wdata);
            chk("m_busy", {busy_o, busy_end_o}, {serving, done});
            chk("m_if_resp", {if_rvalid_o, if_rdata_o}, {m_if_rv, m_if_rd});
            chk("m_mem_resp", {mem_rvalid_o, err_o, mem_rdata_o}, {m_mem_rv, m_err, m_mem_rd});

            m_if_rv = 0; m_mem_rv = 0; m_err = 0;
            if (e_mem_gnt) begin
                m_who = 2; m_age = 0; m_last_mem = 1;
                m_we = mem_we; m_addr = mem_addr; m_wdata = mem_wdata;
                m_wd_ok = 1; m_wmask = mem_wmask;
            end else if (e_if_gnt) begin
                m_who = 1; m_age = 0; m_last_mem = 0;
                m_we = 0; m_addr = if_addr; m_wd_ok = 0; m_wmask = 0;
            end else if (done) begin
                if (m_who == 1) begin
                    m_if_rv = 1; m_if_rd = bus_ack ? bus_rdata : 64'd0;
                end else begin
                    m_mem_rv = 1; m_mem_rd = bus_ack ? bus_rdata : 64'd0;
                end
                m_err = !bus_ack;
                m_who = 0;
            end else if (serving) begin
                m_age++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0;
        mem_addr = 0; mem_wdata = 0; mem_wmask = 0; bus_ack = 0; bus_rdata = 0;

        repeat (2) smp();
        chk("reset_state", {bus_req_o, busy_o, if_gnt_o, mem_gnt_o, err_o,
                            if_rvalid_o, mem_rvalid_o, bus_addr_o}, 0);
        cyc(); rst = 0;

        // IF-only read
        if_req = 1; if_addr = 64'h8000_0000;
        smp(); chk("if_gnt_c0", if_gnt_o, 1);
        cyc(); if_req = 0;
        smp(); chk("if_c1", {busy_o, busy_end_o, bus_req_o, bus_we_o, bus_addr_o},
                   {4'b1010, 64'h8000_0000});
        cyc(); bus_ack = 1; bus_rdata = 64'h13;
        smp(); chk("if_c2_busy_end", {busy_o, busy_end_o}, 2'b11);
        cyc(); bus_ack = 0; bus_rdata = 0;
        smp(); chk("if_c3_rvalid", {if_rvalid_o, busy_o, if_rdata_o}, {2'b10, 64'h13});

        // Contention with last_mem=0: MEM first, IF pending
        cyc(); if_req = 1; mem_req = 1; mem_we = 0; mem_addr = 64'h100;
        smp(); chk("both_mem_first", {if_gnt_o, mem_gnt_o}, 2'b01);
        cyc(); mem_req = 0; bus_ack = 1;
        smp(); chk("no_gnt_while_serving", {if_gnt_o, mem_gnt_o}, 2'b00);
        cyc(); bus_ack = 0;
        smp(); chk("if_after_mem", {if_gnt_o, mem_gnt_o, mem_rvalid_o}, 3'b101);
        cyc(); if_req = 0; bus_ack = 1;
        smp();
        cyc(); bus_ack = 0;

        // Store
        mem_req = 1; mem_we = 1; mem_addr = 64'h8000_1000;
        mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
        smp(); chk("store_gnt", mem_gnt_o, 1);
        cyc(); mem_req = 0; mem_we = 0; mem_addr = 64'h1; mem_wdata = 64'h2; mem_wmask = 8'hF0;
        smp(); chk("store_bus", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o},
                   {2'b11, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F});
        cyc(); bus_ack = 1; bus_rdata = 64'h55;
        smp();
        cyc(); bus_ack = 0; bus_rdata = 0;
        smp(); chk("store_done", {mem_rvalid_o, if_rvalid_o, mem_rdata_o}, {2'b10, 64'h55});
        cyc();
        smp(); chk("rdata_hold", {mem_rvalid_o, mem_rdata_o}, {1'b0, 64'h55});

        // Contention with last_mem=1: IF first, then MEM
        cyc(); if_req = 1; mem_req = 1;
        smp(); chk("both_if_first", {if_gnt_o, mem_gnt_o}, 2'b10);
        cyc(); if_req = 0; bus_ack = 1;
        smp();
        cyc(); bus_ack = 0;
        smp(); chk("mem_after_if", {if_gnt_o, mem_gnt_o}, 2'b01);
        cyc(); mem_req = 0; bus_ack = 1;
        smp();
        cyc(); bus_ack = 0;

        // Timeout abort: no ack
        mem_req = 1; mem_we = 0;
        smp(); chk("to_gnt", mem_gnt_o, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); mem_req = 0;
            smp(); chk("to_serving", {bus_req_o, busy_end_o, err_o}, {1'b1, (k == 4), 1'b0});
        end
        cyc();
        smp(); chk("to_abort", {bus_req_o, err_o, mem_rvalid_o, mem_rdata_o}, {3'b011, 64'h0});

        // Ack on the last permitted cycle completes normally
        cyc(); mem_req = 1;
        smp(); chk("late_gnt", mem_gnt_o, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(); mem_req = 0; bus_ack = (k == 4); bus_rdata = 64'hABC;
            smp();
        end
        cyc(); bus_ack = 0; bus_rdata = 0;
        smp(); chk("late_ack_ok", {err_o, mem_rvalid_o, mem_rdata_o}, {2'b01, 64'hABC});

        // Asynchronous reset mid-transaction, IF left pending
        cyc(); mem_req = 1;
        smp(); chk("rst_mem_gnt", mem_gnt_o, 1);
        cyc(); mem_req = 0; if_req = 1;
        smp(); chk("rst_pre", {bus_req_o, busy_o}, 2'b11);
        @(posedge clk); #2; rst = 1; #1;
        chk("rst_async", {bus_req_o, busy_o}, 2'b00);
        smp(); chk("rst_no_rvalid", {mem_rvalid_o, if_gnt_o}, 2'b00);
        cyc(); rst = 0;
        smp(); chk("rst_if_pending", {if_gnt_o, mem_rvalid_o}, 2'b10);
        cyc(); if_req = 0; bus_ack = 1;
        smp();
        cyc(); bus_ack = 0;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (e_if_gnt) if_req = ($urandom % 4 == 0);
            else if (!if_req) if_req = ($urandom % 3 == 0);
            if (e_mem_gnt) mem_req = ($urandom % 4 == 0);
            else if (!mem_req) mem_req = ($urandom % 3 == 0);
            if_addr   = {$urandom, $urandom};
            mem_addr  = {$urandom, $urandom};
            mem_wdata = {$urandom, $urandom};
            mem_we    = 1'($urandom % 2);
            mem_wmask = 8'($urandom);
            bus_rdata = {$urandom, $urandom};
            bus_ack   = (m_who != 0) ? ($urandom % 4 == 0) : ($urandom % 8 == 0);
        end
        cyc(); if_req = 0; mem_req = 0; bus_ack = 0;
        repeat (2) smp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_axi_arbiter
`default_nettype wire
